pop_accum_ctrl: RTL
===================

// Module: pop_accum_ctrl
// PURPOSE
//  Sequences one Pop popcount core over a long binary vector supplied as POP_SIZE-bit chunks.
//  Accepts chunks on a valid/ready stream, registers each chunk into the Pop operand register,
//  registers the chunk count and accumulates it into a vector sum.
//  Emits the sum plus a thresholded activation bit on a valid/ready output.
//  Sits between the XNOR stage and the activation/writeback stage of a binarized layer.
// PARAMETERS
//  Majority_enable 0   forwarded to Pop; 1 = majority-of-3 mode (POP_SIZE must be a multiple of 3)
//  POP_SIZE        576 chunk width in bits; must not be a power of two (Pop result-width rule)
//  MAX_CHUNKS      16  maximum chunks per vector
//  RES_W           derived; Majority_enable ? $clog2(POP_SIZE/3) : $clog2(POP_SIZE)
//  CNT_W           derived; $clog2(MAX_CHUNKS+1)
//  ACC_W           derived; RES_W + CNT_W
// PORTS
//  clk             in  1        single clock, rising edge
//  reset           in  1        asynchronous, active-low reset
//  cfg_we          in  1        configuration write strobe
//  cfg_num_chunks  in  CNT_W    chunks per vector
//  cfg_threshold   in  ACC_W    activation threshold
//  in_valid        in  1        chunk valid
//  in_ready        out 1        chunk ready
//  in_data         in  POP_SIZE chunk bits
//  out_valid       out 1        result valid
//  out_ready       in  1        result consumed
//  out_sum         out ACC_W    vector popcount
//  out_bit         out 1        out_sum >= threshold
//  busy            out 1        state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_bit=0; busy=0.
//   Also clears the pipe valid flags and chunk counter; num_chunks=MAX_CHUNKS; threshold=0.
//   Reset mid-vector discards all partial work. No partial result is emitted.
//  Config: cfg_we is sampled only in IDLE; it is ignored in every other state.
//   cfg_num_chunks=0 or >MAX_CHUNKS is clamped to 1 or MAX_CHUNKS respectively.
//   A cfg_we in the same cycle as the first chunk handshake applies to that vector.
//  FSM states: IDLE, ACCUM, DRAIN, OUT.
//   IDLE : in_ready=1. On handshake -> ACCUM, or -> DRAIN if num_chunks==1.
//   ACCUM: in_ready=1. Handshake number num_chunks -> DRAIN.
//   DRAIN: in_ready=0. Lasts until the last chunk leaves the adder (2 cycles), then -> OUT.
//   OUT  : out_valid=1; out_sum/out_bit held stable. On out_ready -> IDLE.
//  Pipe, for a handshake at edge N:
//   chunk_q<=in_data @N; pop_q<=Pop(chunk_q) @N+1; acc update @N+2.
//   The first chunk of a vector carries a 'first' tag; the adder uses acc=pop_q, not acc+pop_q.
//   Last handshake at edge L: out_valid rises at edge L+2.
//   out_bit is registered with out_sum at L+2 as (acc_next >= threshold), unsigned compare.
//  Stall: in_valid=0 creates bubbles; pipe stages with valid=0 leave acc unchanged.
//   Throughput is 1 chunk/cycle in ACCUM. in_data need not be held once in_ready=0.
//  Width: ACC_W holds MAX_CHUNKS*max(Pop) with no overflow; no saturation logic.
//  Chunk counter: 0..num_chunks-1; wraps to 0 on the last handshake.
//  No simultaneous in/out overlap: the next vector starts only after the OUT handshake (IDLE).
// STRUCTURE
//  Package pop_pkg: state enum {IDLE,ACCUM,DRAIN,OUT}; RES_W/CNT_W/ACC_W width functions.
//  Sub-module: existing Pop (combinational), instance Pop_inst, params passed through.
//  All remaining logic lives in this module: FSM, counter, 2-stage pipe and accumulator.
// TESTING (POP_SIZE=576, MAX_CHUNKS=16, Majority_enable=0)
//  1. cfg 4 chunks, thr=2000; 4 all-ones chunks back-to-back.
//     -> out_sum=2304, out_bit=1, out_valid 2 cycles after the 4th handshake.
//  2. cfg 1 chunk, thr=101; chunk with 100 ones.
//     -> DRAIN entered from IDLE; out_sum=100, out_bit=0.
//  3. cfg 3 chunks (10, 20, 30 ones) with random in_valid bubbles.
//     -> out_sum=60; acc never changes on bubble cycles.
//  4. hold out_ready=0 for 5 cycles.
//     -> out_valid/out_sum stable, in_ready=0; next vector (2 chunks x 5 ones) -> out_sum=10.
//  5. cfg_we in ACCUM ignored; cfg_num_chunks=0 -> 1.
//     -> 1 chunk (7 ones) gives out_sum=7; cfg_num_chunks=20 -> clamped to 16 chunks.
//  6. reset=0 asynchronously mid-ACCUM (chunk 2 of 4).
//     -> in_ready=1, out_valid=0 immediately; next vector sums from 0.

Source files
------------

// File: rtl/pop_pkg.sv
// Shared types and width helpers for the popcount accumulator and its Pop core.
package pop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Majority mode counts one bit per 3-bit group.
    function automatic int unsigned res_w(input int unsigned maj, input int unsigned pop_size);
        return (maj != 0) ? $clog2(pop_size / 3) : $clog2(pop_size);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_chunks);
        return $clog2(max_chunks + 1);
    endfunction

    function automatic int unsigned acc_w(input int unsigned maj, input int unsigned pop_size,
                                          input int unsigned max_chunks);
        return res_w(maj, pop_size) + cnt_w(max_chunks);
    endfunction

endpackage

// File: rtl/pop_accum_ctrl_pop.sv
// Combinational popcount of one chunk, optionally of 3-bit majority votes.
module Pop
    import pop_pkg::*;
#(
    parameter int unsigned Majority_enable = 0,
    parameter int unsigned POP_SIZE        = 576,
    localparam int unsigned RES_W          = res_w(Majority_enable, POP_SIZE)
) (
    input  logic [POP_SIZE-1:0] data,
    output logic [RES_W-1:0]    count
);

    generate
        if (Majority_enable != 0) begin : g_maj
            always_comb begin
                logic [POP_SIZE-1:0] rest;
                count = '0;
                rest  = data;
                for (int unsigned i = 0; i < POP_SIZE / 3; i++) begin
                    count = count + RES_W'((rest[0] & rest[1]) | (rest[0] & rest[2]) | (rest[1] & rest[2]));
                    rest  = rest >> 3;
                end
            end
        end else begin : g_plain
            always_comb begin
                logic [POP_SIZE-1:0] rest;
                count = '0;
                rest  = data;
                for (int unsigned i = 0; i < POP_SIZE; i++) begin
                    count = count + RES_W'(rest[0]);
                    rest  = rest >> 1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pop_accum_ctrl.sv
// Streams a long binary vector through one Pop core in chunks and accumulates the
// per-chunk counts into a thresholded vector sum.
module pop_accum_ctrl
    import pop_pkg::*;
#(
    parameter int unsigned Majority_enable = 0,
    parameter int unsigned POP_SIZE        = 576,
    parameter int unsigned MAX_CHUNKS      = 16,
    localparam int unsigned RES_W          = res_w(Majority_enable, POP_SIZE),
    localparam int unsigned CNT_W          = cnt_w(MAX_CHUNKS),
    localparam int unsigned ACC_W          = acc_w(Majority_enable, POP_SIZE, MAX_CHUNKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CNT_W-1:0]    cfg_num_chunks,
    input  logic [ACC_W-1:0]    cfg_threshold,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [POP_SIZE-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic                out_bit,
    output logic                busy
);

    state_t               state, state_d;
    logic [CNT_W-1:0]     num_chunks, cnt, cfg_num, num_eff;
    logic [ACC_W-1:0]     threshold, acc, acc_next;
    logic                 cfg_take, hs, last_hs;
    logic [POP_SIZE-1:0]  chunk_q;
    logic                 v1, first1, last1;
    logic [RES_W-1:0]     pop_c, pop_q;
    logic                 v2, first2, last2;

    Pop #(
        .Majority_enable(Majority_enable),
        .POP_SIZE       (POP_SIZE)
    ) Pop_inst (
        .data (chunk_q),
        .count(pop_c)
    );

    // Clamp the requested chunk count into 1..MAX_CHUNKS.
    always_comb begin
        if (cfg_num_chunks == '0) begin
            cfg_num = CNT_W'(1);
        end else if (cfg_num_chunks > CNT_W'(MAX_CHUNKS)) begin
            cfg_num = CNT_W'(MAX_CHUNKS);
        end else begin
            cfg_num = cfg_num_chunks;
        end
    end

    // A config write alongside the first handshake governs that same vector.
    assign cfg_take = cfg_we && (state == IDLE);
    assign num_eff  = cfg_take ? cfg_num : num_chunks;
    assign hs       = in_valid && in_ready;
    assign last_hs  = hs && (cnt == num_eff - CNT_W'(1));
    assign acc_next = first2 ? ACC_W'(pop_q) : acc + ACC_W'(pop_q);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (hs) state_d = last_hs ? DRAIN : ACCUM;
            ACCUM:   if (last_hs) state_d = DRAIN;
            DRAIN:   if (v2 && last2) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE) || (state_d == ACCUM);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == OUT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_chunks <= CNT_W'(MAX_CHUNKS);
            threshold  <= '0;
            cnt        <= '0;
        end else begin
            if (cfg_take) begin
                num_chunks <= cfg_num;
                threshold  <= cfg_threshold;
            end
            if (hs) cnt <= last_hs ? '0 : cnt + CNT_W'(1);
        end
    end

    // Two-stage pipe: operand register, Pop result register, then the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chunk_q <= '0;
            v1      <= 1'b0;
            first1  <= 1'b0;
            last1   <= 1'b0;
            pop_q   <= '0;
            v2      <= 1'b0;
            first2  <= 1'b0;
            last2   <= 1'b0;
            acc     <= '0;
            out_sum <= '0;
            out_bit <= 1'b0;
        end else begin
            v1 <= hs;
            if (hs) begin
                chunk_q <= in_data;
                first1  <= (state == IDLE);
                last1   <= last_hs;
            end
            v2 <= v1;
            if (v1) begin
                pop_q  <= pop_c;
                first2 <= first1;
                last2  <= last1;
            end
            if (v2) acc <= acc_next;
            if (v2 && last2) begin
                out_sum <= acc_next;
                out_bit <= (acc_next >= threshold);
            end
        end
    end

endmodule
